// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator feeding a 2-entry in-order output FIFO with valid/ready on both sides.
// Optional IMM_GEN_PIPE_STATS_EN adds saturating accept and stall counters.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic [2:0]       imm_sel,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [TAG_W-1:0] out_tag,
`ifdef IMM_GEN_PIPE_STATS_EN
   output logic [31:0]      stat_accepted,
   output logic [31:0]      stat_stall,
`endif
   output logic             sel_err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [XLEN-1:0]  imm_c;
   logic             err_c;
   logic             push, pop;
   logic             load0_new, load0_e1, load1_new;

   logic [XLEN-1:0]  e1_imm;
   logic [TAG_W-1:0] e1_tag;
   logic             e1_err;

   // opcode bits never contribute to an immediate
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   always_comb begin
      imm_c = '0;
      err_c = 1'b0;
      case (imm_sel)
         3'd0: imm_c = (XLEN == 32) ? XLEN'(inst[24:20]) : XLEN'(inst[25:20]);
         3'd1: imm_c = XLEN'($signed(inst[31:20]));
         3'd2: imm_c = XLEN'($signed({inst[31:25], inst[11:7]}));
         3'd3: imm_c = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         3'd4: imm_c = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         3'd5: imm_c = XLEN'($signed({inst[31:12], 12'h000}));
         3'd6: imm_c = XLEN'(inst[19:15]);
         default: begin
            imm_c = '0;
            err_c = 1'b1;
         end
      endcase
   end

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // head entry is the presented one; a push in ONE goes to the head only when it pops at the same edge
   always_comb begin
      state_nxt = state;
      load0_new = 1'b0;
      load0_e1  = 1'b0;
      load1_new = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  load0_new = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  load0_new = 1'b1;
               end else if (push) begin
                  load1_new = 1'b1;
                  state_nxt = FULL;
               end else if (pop) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  load0_e1  = 1'b1;
                  state_nxt = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm     <= '0;
         out_tag <= '0;
         sel_err <= 1'b0;
      end else if (load0_new) begin
         imm     <= imm_c;
         out_tag <= in_tag;
         sel_err <= err_c;
      end else if (load0_e1) begin
         imm     <= e1_imm;
         out_tag <= e1_tag;
         sel_err <= e1_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1_imm <= '0;
         e1_tag <= '0;
         e1_err <= 1'b0;
      end else if (load1_new) begin
         e1_imm <= imm_c;
         e1_tag <= in_tag;
         e1_err <= err_c;
      end
   end

`ifdef IMM_GEN_PIPE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_accepted <= '0;
         stat_stall    <= '0;
      end else begin
         if (push && (stat_accepted != '1))
            stat_accepted <= stat_accepted + 32'd1;
         if (out_valid && !out_ready && (stat_stall != '1))
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
